// File: rtl/bjp_pred.sv
// rtl/bjp_pred.sv - next-PC unit with direct-mapped BTB prediction and registered mispredict redirect (optional perf counters: YSYX_23060251_BJP_PERF_EN)
module bjp_pred #(
  parameter int PC_W      = 32,
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16,
  parameter int CNT_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  input  logic [PC_W-1:0] if_pc_i,
  output logic            if_pred_taken_o,
  output logic [PC_W-1:0] if_pred_npc_o,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jal_i,
  input  logic            ex_is_jalr_i,
  input  logic            ex_is_ecall_i,
  input  logic            ex_is_mret_i,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_src1_i,
  input  logic [PC_W-1:0] ex_imm_i,
  input  logic            ex_cnd_i,
  input  logic [XLEN-1:0] ex_csr_data_i,
  input  logic [PC_W-1:0] ex_pred_npc_i,
`ifdef YSYX_23060251_BJP_PERF_EN
  output logic [63:0]     perf_ctrl_o,
  output logic [63:0]     perf_mispred_o,
`endif
  output logic            redirect_valid_o,
  output logic [PC_W-1:0] redirect_pc_o
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WEAK = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t state, next_state;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag     [BTB_DEPTH];
  logic [PC_W-1:0]      btb_target  [BTB_DEPTH];
  logic                 btb_is_jump [BTB_DEPTH];
  logic [CNT_W-1:0]     btb_cnt     [BTB_DEPTH];

  // Fetch-side lookup
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx          = if_pc_i[IDX_W+1:2];
  assign if_tag          = if_pc_i[PC_W-1:IDX_W+2];
  assign if_hit          = if_valid_i & btb_valid[if_idx] & (btb_tag[if_idx] == if_tag);
  assign if_pred_taken_o = if_hit & (btb_is_jump[if_idx] | btb_cnt[if_idx][CNT_W-1]);
  assign if_pred_npc_o   = if_pred_taken_o ? btb_target[if_idx] : (if_pc_i + PC_W'(4));

  // Execute-side resolve
  logic             accept;
  logic             is_ctrl;
  logic             mispredict;
  logic [PC_W-1:0]  pc_plus4, pc_imm, jalr_sum, actual_npc;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [CNT_W-1:0] cnt_next;
  logic             wr_jump, wr_alloc, wr_cnt;

  assign accept     = ex_valid_i & ex_ready_o;
  assign is_ctrl    = ex_is_branch_i | ex_is_jal_i | ex_is_jalr_i | ex_is_ecall_i | ex_is_mret_i;
  assign pc_plus4   = ex_pc_i + PC_W'(4);
  assign pc_imm     = ex_pc_i + ex_imm_i;
  assign jalr_sum   = ex_src1_i[PC_W-1:0] + ex_imm_i;
  assign ex_idx     = ex_pc_i[IDX_W+1:2];
  assign ex_tag     = ex_pc_i[PC_W-1:IDX_W+2];
  assign ex_hit     = btb_valid[ex_idx] & (btb_tag[ex_idx] == ex_tag);
  assign mispredict = accept & (actual_npc != ex_pred_npc_i);

  // Jumps own the entry outright; branches either train a hit or allocate on first taken
  assign wr_jump  = accept & (ex_is_jal_i | ex_is_jalr_i);
  assign wr_alloc = accept & ex_is_branch_i & ~ex_hit & ex_cnd_i & ~wr_jump;
  assign wr_cnt   = accept & ex_is_branch_i & ex_hit & ~wr_jump;

  // Actual next PC, highest-priority source first
  always_comb begin
    actual_npc = pc_plus4;
    if ((ex_is_branch_i & ex_cnd_i) | ex_is_jal_i) begin
      actual_npc = pc_imm;
    end else if (ex_is_jalr_i) begin
      actual_npc = {jalr_sum[PC_W-1:1], 1'b0};
    end else if (ex_is_ecall_i | ex_is_mret_i) begin
      actual_npc = ex_csr_data_i[PC_W-1:0];
    end
  end

  // Saturating counter step for the resolved branch
  always_comb begin
    cnt_next = btb_cnt[ex_idx];
    if (ex_cnd_i && btb_cnt[ex_idx] != CNT_MAX) begin
      cnt_next = btb_cnt[ex_idx] + CNT_W'(1);
    end else if (!ex_cnd_i && btb_cnt[ex_idx] != '0) begin
      cnt_next = btb_cnt[ex_idx] - CNT_W'(1);
    end
  end

  // BTB valid bits are the only entry state that needs reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (wr_jump || wr_alloc) begin
      btb_valid[ex_idx] <= 1'b1;
    end
  end

  // BTB payload write: tag/target/type on allocate, counter on allocate or training
  always_ff @(posedge clk) begin
    if (wr_jump || wr_alloc) begin
      btb_tag[ex_idx]     <= ex_tag;
      btb_target[ex_idx]  <= actual_npc;
      btb_is_jump[ex_idx] <= wr_jump;
    end
    if (wr_alloc) begin
      btb_cnt[ex_idx] <= CNT_WEAK;
    end else if (wr_cnt) begin
      btb_cnt[ex_idx] <= cnt_next;
    end
  end

  // Redirect FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Redirect FSM next state and handshake outputs
  always_comb begin
    next_state       = state;
    ex_ready_o       = 1'b0;
    redirect_valid_o = 1'b0;
    case (state)
      IDLE: begin
        ex_ready_o = 1'b1;
        if (mispredict) begin
          next_state = FLUSH;
        end
      end
      FLUSH: begin
        redirect_valid_o = 1'b1;
        next_state       = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Redirect target captured at the mispredicting accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_pc_o <= '0;
    end else if (mispredict) begin
      redirect_pc_o <= actual_npc;
    end
  end

`ifdef YSYX_23060251_BJP_PERF_EN
  // Control-flow and mispredict event counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ctrl_o    <= '0;
      perf_mispred_o <= '0;
    end else begin
      if (accept && is_ctrl) begin
        perf_ctrl_o <= perf_ctrl_o + 64'd1;
      end
      if (mispredict) begin
        perf_mispred_o <= perf_mispred_o + 64'd1;
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = is_ctrl;
`endif

endmodule

// File: tb/tb_bjp_pred.sv
// tb/tb_bjp_pred.sv - scoreboard testbench for bjp_pred
module tb_bjp_pred;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic        if_pred_taken_o;
  logic [31:0] if_pred_npc_o;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic        ex_is_branch_i = 1'b0, ex_is_jal_i = 1'b0, ex_is_jalr_i = 1'b0;
  logic        ex_is_ecall_i = 1'b0, ex_is_mret_i = 1'b0;
  logic [31:0] ex_pc_i = '0, ex_src1_i = '0, ex_imm_i = '0;
  logic        ex_cnd_i = 1'b0;
  logic [31:0] ex_csr_data_i = '0, ex_pred_npc_i = '0;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
`ifdef YSYX_23060251_BJP_PERF_EN
  logic [63:0] perf_ctrl_o, perf_mispred_o;
`endif

  bjp_pred dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
    .if_pred_taken_o(if_pred_taken_o), .if_pred_npc_o(if_pred_npc_o),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_is_branch_i(ex_is_branch_i), .ex_is_jal_i(ex_is_jal_i), .ex_is_jalr_i(ex_is_jalr_i),
    .ex_is_ecall_i(ex_is_ecall_i), .ex_is_mret_i(ex_is_mret_i),
    .ex_pc_i(ex_pc_i), .ex_src1_i(ex_src1_i), .ex_imm_i(ex_imm_i), .ex_cnd_i(ex_cnd_i),
    .ex_csr_data_i(ex_csr_data_i), .ex_pred_npc_i(ex_pred_npc_i),
`ifdef YSYX_23060251_BJP_PERF_EN
    .perf_ctrl_o(perf_ctrl_o), .perf_mispred_o(perf_mispred_o),
`endif
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [31:0] exp_pc_q[$];
  int          exp_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every redirect pulse must match the oldest expected redirect, at the expected cycle
  always @(negedge clk) begin
    if (!rst && redirect_valid_o) begin
      if (exp_pc_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_redirect: got pc 0x%0h expected none", redirect_pc_o);
      end else begin
        check("redirect_pc", redirect_pc_o, exp_pc_q.pop_front());
        check("redirect_cycle", cyc, exp_cyc_q.pop_front());
        check("ready_in_flush", ex_ready_o, 0);
      end
    end
  end

  task automatic lookup(input string name, input logic v, input logic [31:0] pc,
                        input logic exp_t, input logic [31:0] exp_npc);
    @(negedge clk);
    if_valid_i = v;
    if_pc_i    = pc;
    #1;
    check({name, "_taken"}, if_pred_taken_o, exp_t);
    check({name, "_npc"}, if_pred_npc_o, exp_npc);
    if_valid_i = 1'b0;
  endtask

  // flags = {branch, jal, jalr, ecall, mret}
  task automatic resolve(input logic [4:0] flags, input logic [31:0] pc, input logic [31:0] src1,
                         input logic [31:0] imm, input logic cnd, input logic [31:0] csr,
                         input logic [31:0] pred, input logic exp_redir, input logic [31:0] exp_pc);
    bit done = 0;
    @(negedge clk);
    {ex_is_branch_i, ex_is_jal_i, ex_is_jalr_i, ex_is_ecall_i, ex_is_mret_i} = flags;
    ex_pc_i = pc; ex_src1_i = src1; ex_imm_i = imm; ex_cnd_i = cnd;
    ex_csr_data_i = csr; ex_pred_npc_i = pred;
    ex_valid_i = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (ex_ready_o) begin
        if (exp_redir) begin
          exp_pc_q.push_back(exp_pc);
          exp_cyc_q.push_back(cyc + 1);
        end
        done = 1;
      end
      @(negedge clk);
      if (done) ex_valid_i = 1'b0;
    end
    ex_valid_i = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got ready 0 expected 1");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_redirect_valid", redirect_valid_o, 0);
    check("rst_redirect_pc", redirect_pc_o, 0);
    check("rst_ready", ex_ready_o, 1);
    lookup("rst_lookup", 1, 32'h8000_0000, 0, 32'h8000_0004);

    // Branch training at 0x80000010 (BTB index 4)
    resolve(5'b10000, 32'h8000_0010, 0, 32'h20, 1, 0, 32'h8000_0014, 1, 32'h8000_0030);
    lookup("br_alloc", 1, 32'h8000_0010, 1, 32'h8000_0030);
    resolve(5'b10000, 32'h8000_0010, 0, 32'h20, 0, 0, 32'h8000_0030, 1, 32'h8000_0014);
    lookup("br_cnt01", 1, 32'h8000_0010, 0, 32'h8000_0014);
    resolve(5'b10000, 32'h8000_0010, 0, 32'h20, 0, 0, 32'h8000_0014, 0, 0);
    resolve(5'b10000, 32'h8000_0010, 0, 32'h20, 0, 0, 32'h8000_0014, 0, 0);
    // Back-to-back mispredicts from a saturated-low counter: 00 -> 01 -> 10
    resolve(5'b10000, 32'h8000_0010, 0, 32'h20, 1, 0, 32'h8000_0014, 1, 32'h8000_0030);
    resolve(5'b10000, 32'h8000_0010, 0, 32'h20, 1, 0, 32'h8000_0014, 1, 32'h8000_0030);
    lookup("br_sat_low", 1, 32'h8000_0010, 1, 32'h8000_0030);

    // jalr with bit0 cleared: predicted correctly, entry becomes a jump
    resolve(5'b00100, 32'h8000_0040, 32'h8000_1001, 32'h4, 0, 0, 32'h8000_1004, 0, 0);
    lookup("jalr_entry", 1, 32'h8000_0040, 1, 32'h8000_1004);

    // mret at 0x80000050 shares index 4 but must not write
    resolve(5'b00001, 32'h8000_0050, 0, 0, 0, 32'h8000_0100, 32'h8000_0054, 1, 32'h8000_0100);
    lookup("mret_nowrite", 1, 32'h8000_0050, 0, 32'h8000_0054);
    lookup("mret_keep", 1, 32'h8000_0010, 1, 32'h8000_0030);

    // jal backwards
    resolve(5'b01000, 32'h8000_0060, 0, 32'hFFFF_FFE0, 0, 0, 32'h8000_0064, 1, 32'h8000_0040);
    lookup("jal_entry", 1, 32'h8000_0060, 1, 32'h8000_0040);

    // Not-taken miss does not write; taken miss overwrites the conflicting index
    resolve(5'b10000, 32'h8000_0410, 0, 32'h10, 0, 0, 32'h8000_0414, 0, 0);
    lookup("nt_miss_nowrite", 1, 32'h8000_0010, 1, 32'h8000_0030);
    resolve(5'b10000, 32'h8000_0410, 0, 32'h10, 1, 0, 32'h8000_0414, 1, 32'h8000_0420);
    lookup("conflict_new", 1, 32'h8000_0410, 1, 32'h8000_0420);
    lookup("conflict_old", 1, 32'h8000_0010, 0, 32'h8000_0014);

    // No control flag: actual is pc+4
    resolve(5'b00000, 32'h8000_0070, 0, 32'h40, 1, 32'h1234, 32'h8000_0074, 0, 0);
    resolve(5'b00000, 32'h8000_0070, 0, 32'h40, 1, 32'h1234, 32'h8000_0078, 1, 32'h8000_0074);

    // ecall to mtvec
    resolve(5'b00010, 32'h8000_0080, 0, 0, 0, 32'h8000_0200, 32'h8000_0084, 1, 32'h8000_0200);

    // Invalid fetch never predicts taken
    lookup("if_invalid", 0, 32'h8000_0040, 0, 32'h8000_0044);

    // Reset during FLUSH drops the pulse immediately and clears the BTB
    resolve(5'b01000, 32'h8000_0090, 0, 32'h100, 0, 0, 32'h8000_0094, 1, 32'h8000_0190);
    #2;
    rst = 1'b1;
    #1;
    check("rst_flush_valid", redirect_valid_o, 0);
    check("rst_flush_ready", ex_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;
    lookup("post_rst_jalr", 1, 32'h8000_0040, 0, 32'h8000_0044);
    lookup("post_rst_jal", 1, 32'h8000_0090, 0, 32'h8000_0094);

    repeat (3) @(negedge clk);
    check("pending_redirects", exp_pc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
